// File: rtl/mode_sequencer.sv
// Front-panel mode sequencer: three debounced buttons drive a MENU/SWITCH/RUN
// controller that gates the mode engines and beeps while switching.

module ms_btn #(
   parameter int DEBOUNCE_CYC = 2000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press
);
   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);

   logic          sync1_q, sync2_q, level_q, press_q;
   logic          level_d, press_d;
   logic [DW-1:0] cnt_q, cnt_d;

   // Count only while the synchronised input disagrees with the accepted level;
   // any agreement (a bounce back) restarts the count.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == DB_LAST) level_d = sync2_q;
         else                  cnt_d   = cnt_q + DW'(1);
      end
      press_d = level_d & ~level_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;
endmodule

module mode_sequencer #(
   parameter int NUM_MODES    = 4,
   parameter int DEBOUNCE_CYC = 2000000,
   parameter int GUARD_CYC    = 10000000,
   parameter int TONE_HALF    = 50000,
   localparam int MODE_W      = (NUM_MODES <= 2) ? 1 : $clog2(NUM_MODES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 btn_sel,
   input  logic                 btn_ok,
   input  logic                 btn_back,
   input  logic [NUM_MODES-1:0] mode_sig,
   output logic [MODE_W-1:0]    mode,
   output logic [MODE_W-1:0]    cand,
   output logic [NUM_MODES-1:0] mode_en,
   output logic                 signal,
   output logic                 mode_changed
);
   localparam int GW = $clog2(GUARD_CYC + 1);
   localparam int TW = $clog2(TONE_HALF + 1);
   localparam logic [GW-1:0]        GUARD_LAST = GW'(GUARD_CYC - 1);
   localparam logic [TW-1:0]        TONE_LAST  = TW'(TONE_HALF - 1);
   localparam logic [MODE_W-1:0]    CAND_LAST  = MODE_W'(NUM_MODES - 1);
   localparam logic [NUM_MODES-1:0] EN_MENU    = NUM_MODES'(1);

   typedef enum logic [1:0] {MENU, SWITCH, RUN} state_t;

   // press[0]=sel, press[1]=ok, press[2]=back
   logic [2:0] btn_raw, press;
   assign btn_raw = {btn_back, btn_ok, btn_sel};

   for (genvar b = 0; b < 3; b++) begin : g_btn
      ms_btn #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
         .clk    (clk),
         .rst    (rst),
         .btn_raw(btn_raw[b]),
         .press  (press[b])
      );
   end

   state_t                 state_q, state_d;
   logic [MODE_W-1:0]      cand_q, cand_d, target_q, target_d, mode_q, mode_d;
   logic [NUM_MODES-1:0]   mode_en_q, mode_en_d;
   logic                   signal_q, signal_d, mode_changed_q, mode_changed_d;
   logic [GW-1:0]          guard_q, guard_d;
   logic [TW-1:0]          tone_q, tone_d;
   logic                   back_p, ok_p, sel_p;

   // Fixed priority: a lower-priority press in the same cycle is dropped.
   assign back_p = press[2];
   assign ok_p   = press[1] & ~press[2];
   assign sel_p  = press[0] & ~press[1] & ~press[2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= MENU;
         cand_q         <= MODE_W'(1);
         target_q       <= '0;
         mode_q         <= '0;
         mode_en_q      <= EN_MENU;
         signal_q       <= 1'b0;
         mode_changed_q <= 1'b0;
         guard_q        <= '0;
         tone_q         <= '0;
      end else begin
         state_q        <= state_d;
         cand_q         <= cand_d;
         target_q       <= target_d;
         mode_q         <= mode_d;
         mode_en_q      <= mode_en_d;
         signal_q       <= signal_d;
         mode_changed_q <= mode_changed_d;
         guard_q        <= guard_d;
         tone_q         <= tone_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      target_d = target_q;
      guard_d  = '0;
      tone_d   = '0;
      case (state_q)
         MENU: begin
            if (ok_p) begin
               target_d = cand_q;
               state_d  = SWITCH;
            end else if (sel_p) begin
               cand_d = (cand_q == CAND_LAST) ? MODE_W'(1) : cand_q + MODE_W'(1);
            end
         end
         SWITCH: begin
            if (guard_q == GUARD_LAST) begin
               state_d = (target_q != '0) ? RUN : MENU;
            end else begin
               guard_d = guard_q + GW'(1);
               tone_d  = (tone_q == TONE_LAST) ? '0 : tone_q + TW'(1);
            end
         end
         RUN: begin
            if (back_p) begin
               target_d = '0;
               state_d  = SWITCH;
            end
         end
         default: state_d = MENU;
      endcase
   end

   // Outputs are computed from the next state so the registered values line
   // up with the state they describe.
   always_comb begin
      mode_d         = mode_q;
      mode_en_d      = '0;
      signal_d       = 1'b0;
      mode_changed_d = (state_q == SWITCH) && (state_d != SWITCH);
      case (state_d)
         MENU: begin
            mode_d    = '0;
            mode_en_d = EN_MENU;
            signal_d  = mode_sig[0];
         end
         SWITCH: begin
            if (state_q == SWITCH)
               signal_d = (tone_q == TONE_LAST) ? ~signal_q : signal_q;
         end
         RUN: begin
            mode_d    = target_d;
            mode_en_d = EN_MENU << target_d;
            signal_d  = mode_sig[target_d];
         end
         default: mode_d = '0;
      endcase
   end

   assign mode         = mode_q;
   assign cand         = cand_q;
   assign mode_en      = mode_en_q;
   assign signal       = signal_q;
   assign mode_changed = mode_changed_q;
endmodule
